ps2_keyboard_to_ascii: RTL and testbench
========================================

Name: ps2_keyboard_to_ascii

Overview:
- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines.
- Decodes set-2 scan codes, tracking make/break codes and the shift/ctrl modifiers.
- Emits 7-bit Apple-1-style ASCII (uppercase only) with a one-cycle strobe.
- Sits between the keyboard connector and the terminal/PIA keyboard input.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- DEBOUNCE_BITS, 8: width of the counter that filters the ps2 lines; a line must be stable for 2^DEBOUNCE_BITS clk cycles.
- IDLE_US, 100: ps2_clk high time in microseconds after which a partial frame is discarded.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- ascii_code  out  7  last decoded character.
- ascii_new  out  1  one-clk pulse when ascii_code is updated.

Behaviour:
- Reset: ascii_code=0x00, ascii_new=0, bit counter=0, break/extended/shift/ctrl flags all cleared.
- Input conditioning:
  - 2-FF synchronizer on each line.
  - Debounce: the filtered value updates only after the synced value has been stable 2^DEBOUNCE_BITS cycles.
  - A falling edge of filtered ps2_clk is a sample point.
- Frame format: 11 bits, each sampled on a falling edge, in this order:
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity bit;
  - stop bit = 1.
- Frame acceptance: valid only if start=0, stop=1, and the XOR of the data and parity bits is 1.
  - Invalid frames are dropped silently; decoder flags are unchanged.
- Idle timeout: filtered ps2_clk high for IDLE_US (CLK_FREQ/1e6*IDLE_US cycles) while a frame is partial resets the bit counter to 0.
  - The timeout must tolerate a 43.2 µs half-period without firing.
- Decoder states: IDLE, BREAK_PENDING (after 0xF0), EXT_PENDING (after 0xE0).
  - 0xE0 sets the extended flag; 0xF0 sets the break flag.
  - The next non-prefix code consumes both flags and clears them.
  - A break of 0x12/0x59 clears shift; a break of 0x14 clears ctrl; any other break produces no output.
  - A make of 0x12/0x59 sets shift; a make of 0x14 sets ctrl; modifiers produce no output.
  - Extended codes produce no output, except E0 5A (keypad enter) → 0x0D and E0 14 (right ctrl), which is handled as ctrl.
- Mapping of a make code:
  - Letters: always uppercase (0x1C→0x41 'A', etc.), shift ignored.
  - Ctrl+letter → uppercase letter & 0x1F.
  - Digits/punctuation: unshifted/shifted US layout, folded to 0x20–0x5F; any lowercase result is forced upper (bit 5 cleared).
  - 0x29→0x20, 0x5A→0x0D, 0x66 (backspace)→0x5F, 0x76→0x1B.
  - Unmapped codes produce no output.
- Output timing:
  - On a mapped make code, ascii_code is loaded and ascii_new pulses high for exactly one clk.
  - The pulse occurs no later than 2^DEBOUNCE_BITS+8 cycles after the raw 11th falling edge.
  - ascii_code holds its value until the next mapped key.
- Typematic: repeated make codes without an intervening break each produce a new pulse.
- Reset mid-frame: all state clears immediately; the next start bit begins a fresh frame.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants (SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CTRL=0x14, SC_ENTER=0x5A, SC_BKSP=0x66, SC_ESC=0x76);
  - ASCII constants (CR, ESC, RUBOUT);
  - the decoder state enum.
- Sub-module ps2_rx: synchronizer, debounce, 11-bit shift, parity/framing check, idle timeout.
  - Outputs: rx_code[7:0] and rx_valid (1-cycle pulse).
- The top level holds the decoder FSM and the mapping function.

Test Plan:
- Frame 0x1C ('A'), half-period 43.2 µs, parity 0, stop 1 → one ascii_new pulse, ascii_code=0x41.
- Same frame repeated after 500 µs idle, no break → second pulse, ascii_code=0x41.
- Sequence 12, 16, F0 16, F0 12 ('!' with shift) → single pulse with 0x21; the break codes produce no pulse.
- 0x1C sent with parity 1 → no pulse; a following good 0x5A frame → pulse with 0x0D.
- Mid-frame abort after 5 bits, then 150 µs of ps2_clk high, then a full 0x29 frame → a single pulse with 0x20.
- Ctrl hold (14), 0x21 ('C'), F0 21, F0 14 → pulse with 0x03.
- reset_n low during a frame → outputs 0; a subsequent valid 0x1C frame → 0x41.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Scan codes are set 2; ASCII is 7-bit Apple-1 style.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [6:0] CR     = 7'h0D;
  localparam logic [6:0] ESC    = 7'h1B;
  localparam logic [6:0] RUBOUT = 7'h5F;

  typedef enum logic [1:0] {
    IDLE,
    BREAK_PENDING,
    EXT_PENDING
  } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, debounce, 11-bit shift, framing check.
// A stalled partial frame is dropped after the idle timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int DEBOUNCE_BITS = 8,
  parameter int IDLE_US       = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_code,
  output logic       rx_valid
);

  localparam int IDLE_CYC = CLK_FREQ / 1_000_000 * IDLE_US;
  localparam int IW       = $clog2(IDLE_CYC + 1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

  // bit 0 is the clock line, bit 1 the data line
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] filt;
  logic [DEBOUNCE_BITS-1:0] db_cnt [2];

  logic          clk_q;
  logic          fall;
  logic [9:0]    sr;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;

  assign raw  = {ps2_data, ps2_clk};
  assign fall = clk_q & ~filt[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '1;
      s2        <= '1;
      filt      <= '1;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          filt[i]   <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DEBOUNCE_BITS'(1);
        end
      end
    end
  end

  // sr collects start, data and parity; the stop bit is checked live
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_q    <= 1'b1;
      sr       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      rx_code  <= '0;
      rx_valid <= 1'b0;
    end else begin
      clk_q    <= filt[0];
      rx_valid <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          bit_cnt <= '0;
          if (!sr[0] && filt[1] && ^sr[9:1]) begin
            rx_code  <= sr[8:1];
            rx_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          sr      <= {filt[1], sr[9:1]};
        end
      end else if (bit_cnt != '0 && filt[0]) begin
        if (idle_cnt == IW'(IDLE_CYC)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_to_ascii.sv
// PS/2 set-2 keyboard to uppercase Apple-1 ASCII with a one-clk strobe.
// Tracks break/extended prefixes and the shift/ctrl modifiers.
module ps2_keyboard_to_ascii
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int DEBOUNCE_BITS = 8,
  parameter int IDLE_US       = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] ascii_code,
  output logic       ascii_new
);

  logic [7:0] rx_code;
  logic       rx_valid;

  ps2_rx #(
    .CLK_FREQ      (CLK_FREQ),
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .IDLE_US       (IDLE_US)
  ) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_code  (rx_code),
    .rx_valid (rx_valid)
  );

  // returns {hit, ascii}
  function automatic logic [7:0] map_key(
    input logic [7:0] sc,
    input logic       sh,
    input logic       ct
  );
    logic [6:0] a;
    logic       hit;
    a   = 7'h00;
    hit = 1'b1;
    case (sc)
      8'h1C: a = 7'h41;
      8'h32: a = 7'h42;
      8'h21: a = 7'h43;
      8'h23: a = 7'h44;
      8'h24: a = 7'h45;
      8'h2B: a = 7'h46;
      8'h34: a = 7'h47;
      8'h33: a = 7'h48;
      8'h43: a = 7'h49;
      8'h3B: a = 7'h4A;
      8'h42: a = 7'h4B;
      8'h4B: a = 7'h4C;
      8'h3A: a = 7'h4D;
      8'h31: a = 7'h4E;
      8'h44: a = 7'h4F;
      8'h4D: a = 7'h50;
      8'h15: a = 7'h51;
      8'h2D: a = 7'h52;
      8'h1B: a = 7'h53;
      8'h2C: a = 7'h54;
      8'h3C: a = 7'h55;
      8'h2A: a = 7'h56;
      8'h1D: a = 7'h57;
      8'h22: a = 7'h58;
      8'h35: a = 7'h59;
      8'h1A: a = 7'h5A;
      8'h16: a = sh ? 7'h21 : 7'h31;
      8'h1E: a = sh ? 7'h40 : 7'h32;
      8'h26: a = sh ? 7'h23 : 7'h33;
      8'h25: a = sh ? 7'h24 : 7'h34;
      8'h2E: a = sh ? 7'h25 : 7'h35;
      8'h36: a = sh ? 7'h5E : 7'h36;
      8'h3D: a = sh ? 7'h26 : 7'h37;
      8'h3E: a = sh ? 7'h2A : 7'h38;
      8'h46: a = sh ? 7'h28 : 7'h39;
      8'h45: a = sh ? 7'h29 : 7'h30;
      8'h4E: a = sh ? 7'h5F : 7'h2D;
      8'h55: a = sh ? 7'h2B : 7'h3D;
      8'h54: a = sh ? 7'h7B : 7'h5B;
      8'h5B: a = sh ? 7'h7D : 7'h5D;
      8'h5D: a = sh ? 7'h7C : 7'h5C;
      8'h4C: a = sh ? 7'h3A : 7'h3B;
      8'h52: a = sh ? 7'h22 : 7'h27;
      8'h0E: a = sh ? 7'h7E : 7'h60;
      8'h41: a = sh ? 7'h3C : 7'h2C;
      8'h49: a = sh ? 7'h3E : 7'h2E;
      8'h4A: a = sh ? 7'h3F : 7'h2F;
      8'h29: a = 7'h20;
      SC_ENTER: a = CR;
      SC_BKSP:  a = RUBOUT;
      SC_ESC:   a = ESC;
      default:  hit = 1'b0;
    endcase
    // fold 0x60-0x7F onto the uppercase half
    if (a[6:5] == 2'b11) a[5] = 1'b0;
    if (ct && a >= 7'h41 && a <= 7'h5A) a = a & 7'h1F;
    return {hit, a};
  endfunction

  dec_state_t state_q;
  dec_state_t state_d;
  logic       ext_q;
  logic       ext_d;
  logic       shift_q;
  logic       shift_d;
  logic       ctrl_q;
  logic       ctrl_d;
  logic [6:0] code_d;
  logic       new_d;
  logic       brk;
  logic [7:0] km;

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    code_d  = ascii_code;
    new_d   = 1'b0;
    brk     = (state_q == BREAK_PENDING);
    km      = map_key(rx_code, shift_q, ctrl_q);
    if (rx_valid) begin
      unique case (1'b1)
        rx_code == SC_BREAK: state_d = BREAK_PENDING;
        rx_code == SC_EXT: begin
          ext_d = 1'b1;
          if (!brk) state_d = EXT_PENDING;
        end
        default: begin
          state_d = IDLE;
          ext_d   = 1'b0;
          if (rx_code == SC_CTRL) begin
            ctrl_d = !brk;
          end else if (ext_q) begin
            if (!brk && rx_code == SC_ENTER) begin
              code_d = CR;
              new_d  = 1'b1;
            end
          end else if (rx_code == SC_LSHIFT ||
                       rx_code == SC_RSHIFT) begin
            shift_d = !brk;
          end else if (!brk && km[7]) begin
            code_d = km[6:0];
            new_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ext_q      <= 1'b0;
      shift_q    <= 1'b0;
      ctrl_q     <= 1'b0;
      ascii_code <= '0;
      ascii_new  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      shift_q    <= shift_d;
      ctrl_q     <= ctrl_d;
      ascii_code <= code_d;
      ascii_new  <= new_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_to_ascii.sv
// Scoreboard bench for ps2_keyboard_to_ascii with a keymap model.
// One clk period is 10 time units, i.e. 1 us at CLK_FREQ = 1 MHz.
module tb_ps2_keyboard_to_ascii;

  localparam int CLK_FREQ = 1_000_000;
  localparam int DB       = 3;
  localparam int IDLE_US  = 100;
  localparam int US       = 10;
  localparam int HALF     = 432;
  localparam int LAT_MAX  = 2 ** DB + 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] ascii_code;
  logic       ascii_new;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;

  logic [6:0] exp_q[$];
  logic [6:0] last_exp = 7'h00;
  logic       prev_new = 1'b0;

  bit m_brk, m_ext, m_shift, m_ctrl;
  logic [6:0] unsh_map [logic [7:0]];
  logic [6:0] sh_map [logic [7:0]];
  bit         is_letter [logic [7:0]];

  logic [7:0] pool [22] = '{
    8'h1C, 8'h32, 8'h21, 8'h15, 8'h1A,
    8'h16, 8'h1E, 8'h0E, 8'h54, 8'h5D, 8'h52, 8'h4A,
    8'h12, 8'h59, 8'h14,
    8'h29, 8'h5A, 8'h66, 8'h76,
    8'h05, 8'h77, 8'h7E
  };

  ps2_keyboard_to_ascii #(
    .CLK_FREQ      (CLK_FREQ),
    .DEBOUNCE_BITS (DB),
    .IDLE_US       (IDLE_US)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii_code (ascii_code),
    .ascii_new  (ascii_new)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] fold(input byte unsigned c);
    byte unsigned v;
    v = c;
    if (v >= 8'h60) v = v - 8'h20;
    return v[6:0];
  endfunction

  task automatic init_tables();
    logic [7:0] lsc [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    logic [7:0] ssc [21] = '{
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
      8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B,
      8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E
    };
    byte unsigned lo [21] = '{
      8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
      8'h38, 8'h39, 8'h30, 8'h2D, 8'h3D, 8'h5B, 8'h5D,
      8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60
    };
    byte unsigned hi [21] = '{
      8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
      8'h2A, 8'h28, 8'h29, 8'h5F, 8'h2B, 8'h7B, 8'h7D,
      8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h7E
    };
    for (int i = 0; i < 26; i++) begin
      is_letter[lsc[i]] = 1'b1;
      unsh_map[lsc[i]]  = 7'(8'h41 + i);
      sh_map[lsc[i]]    = 7'(8'h41 + i);
    end
    for (int i = 0; i < 21; i++) begin
      unsh_map[ssc[i]] = fold(lo[i]);
      sh_map[ssc[i]]   = fold(hi[i]);
    end
    unsh_map[8'h29] = 7'h20; sh_map[8'h29] = 7'h20;
    unsh_map[8'h5A] = 7'h0D; sh_map[8'h5A] = 7'h0D;
    unsh_map[8'h66] = 7'h5F; sh_map[8'h66] = 7'h5F;
    unsh_map[8'h76] = 7'h1B; sh_map[8'h76] = 7'h1B;
  endtask

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_ctrl = 0;
    last_exp = 7'h00;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit brk, ext;
    logic [6:0] c;
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      brk = m_brk;
      ext = m_ext;
      m_brk = 0;
      m_ext = 0;
      if (b == 8'h14) begin
        m_ctrl = !brk;
      end else if (ext) begin
        if (!brk && b == 8'h5A) exp_q.push_back(7'h0D);
      end else if (b == 8'h12 || b == 8'h59) begin
        m_shift = !brk;
      end else if (!brk && unsh_map.exists(b)) begin
        c = m_shift ? sh_map[b] : unsh_map[b];
        if (is_letter.exists(b) && m_ctrl) c = c & 7'h1F;
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic send_bits(input logic [10:0] f,
                           input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #(half);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      #(half);
      ps2_clk  = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input bit bp, input bit bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bp,
                           input bit bs, input int half);
    logic [10:0] f;
    f = frame(b, bp, bs);
    send_bits(f, 10, half);
    ps2_data = f[10];
    #(half);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    if (!bp && !bs) model_byte(b);
    #(half);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    #(2 * half);
  endtask

  task automatic checkpoint(input string name);
    repeat (LAT_MAX + 2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (ascii_code !== last_exp) begin
      bad++;
      $display("FAIL %s_hold got=%h want=%h", name, ascii_code, last_exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [6:0] e;
    if (reset_n && ascii_new) begin
      total++;
      if (prev_new) begin
        bad++;
        $display("FAIL pulse_width got=2+ cycles want=1");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%h want=none", ascii_code);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        if (ascii_code !== e) begin
          bad++;
          $display("FAIL code got=%h want=%h", ascii_code, e);
        end
        total++;
        if (cyc - fall_cyc > LAT_MAX) begin
          bad++;
          $display("FAIL latency got=%0d want<=%0d",
                   cyc - fall_cyc, LAT_MAX);
        end
      end
    end
    prev_new = reset_n && ascii_new;
  end

  initial begin
    logic [7:0] seq[$];
    int half;
    init_tables();
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (ascii_code !== 7'h00 || ascii_new !== 1'b0) begin
      bad++;
      $display("FAIL reset got=%h/%b want=00/0", ascii_code, ascii_new);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (ascii_code !== 7'h00 || ascii_new !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got=%h/%b want=00/0",
               ascii_code, ascii_new);
    end

    send_byte(8'h1C, 0, 0, HALF);
    checkpoint("a_key");

    #(500 * US);
    send_byte(8'h1C, 0, 0, HALF);
    checkpoint("typematic");

    send_byte(8'h12, 0, 0, HALF);
    send_byte(8'h16, 0, 0, HALF);
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'h16, 0, 0, HALF);
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'h12, 0, 0, HALF);
    checkpoint("shift_bang");

    send_byte(8'h1C, 1, 0, HALF);
    checkpoint("bad_parity");
    send_byte(8'h5A, 0, 0, HALF);
    checkpoint("enter");

    send_bits(frame(8'h1C, 0, 0), 5, HALF);
    #(150 * US);
    send_byte(8'h29, 0, 0, HALF);
    checkpoint("abort_space");

    send_byte(8'h14, 0, 0, HALF);
    send_byte(8'h21, 0, 0, HALF);
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'h21, 0, 0, HALF);
    send_byte(8'hF0, 0, 0, HALF);
    send_byte(8'h14, 0, 0, HALF);
    checkpoint("ctrl_c");

    send_byte(8'hE0, 0, 0, HALF);
    send_byte(8'h5A, 0, 0, HALF);
    checkpoint("kp_enter");

    send_bits(frame(8'h1C, 0, 0), 5, HALF);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (ascii_code !== 7'h00 || ascii_new !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b want=00/0",
               ascii_code, ascii_new);
    end
    reset_n = 1'b1;
    #(20 * US);
    send_byte(8'h1C, 0, 0, HALF);
    checkpoint("after_reset");

    for (int n = 0; n < 30; n++) begin
      seq.delete();
      half = $urandom_range(15, 43) * US;
      if ($urandom_range(0, 7) == 0) seq.push_back(8'hE0);
      if ($urandom_range(0, 2) == 0) seq.push_back(8'hF0);
      seq.push_back(pool[$urandom_range(0, 21)]);
      foreach (seq[k])
        send_byte(seq[k], $urandom_range(0, 11) == 0,
                  $urandom_range(0, 24) == 0, half);
      if (n % 10 == 9) checkpoint("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
